// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store front end for a 32-bit, byte-addressable,
// write-first data memory with a synchronous read port. The unit handles one
// request at a time:
//   IDLE -> ACCESS -> RESP           stores (3 cycles)
//   IDLE -> ACCESS -> WAIT -> RESP   loads (4 cycles)
//   IDLE -> RESP                     rejected requests (2 cycles)
// Build option: define MISALIGN_TRAP_EN to reject misaligned half/word
// accesses with resp_err. When it is left undefined, the low offset bits are
// truncated and the access goes ahead.
module load_store_unit #(
  parameter int MEM_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_funct3,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic [3:0]                mem_byte_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_din,
  input  logic [31:0]               mem_dout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // Access size, taken from funct3[1:0]
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]                state_reg, state_next;
  logic                      we_reg;
  logic [2:0]                f3_reg;
  logic [1:0]                off_reg;
  logic [3:0]                be_reg;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_reg;
  logic [31:0]               mem_din_reg;
  logic [31:0]               resp_rdata_reg;
  logic                      resp_err_reg;

  // Request decode (combinational, used only while IDLE)
  logic [1:0]  size_in;
  logic [1:0]  off_in;
  logic [1:0]  off_use;
  logic        f3_legal;
  logic        misaligned_in;
  logic        trap_in;
  logic        err_in;
  logic [3:0]  be_in;
  logic [31:0] din_in;

  // Load extraction
  logic [7:0]  rd_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // The memory only sees the word-address bits; anything above them wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:MEM_ADDR_WIDTH+2];

  assign size_in = req_funct3[1:0];
  assign off_in  = req_addr[1:0];

  // Legal: B/H/W in either direction, BU/HU only as loads.
  always_comb begin
    f3_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~req_we;
      default:                f3_legal = 1'b0;
    endcase
  end

  assign misaligned_in = ((size_in == SZ_HALF) && off_in[0]) ||
                         ((size_in == SZ_WORD) && (off_in != 2'b00));

`ifdef MISALIGN_TRAP_EN
  assign trap_in = misaligned_in;
`else
  assign trap_in = 1'b0;
`endif

  assign err_in = ~f3_legal | trap_in;

  // Drop the offset bits that the access size cannot use. When misaligned
  // requests are trapped this never changes an accepted request.
  always_comb begin
    off_use = off_in;
    case (size_in)
      SZ_HALF: off_use = {off_in[1], 1'b0};
      SZ_WORD: off_use = 2'b00;
      default: off_use = off_in;
    endcase
  end

  // Byte enables for the store lanes
  always_comb begin
    be_in = 4'b1111;
    case (size_in)
      SZ_BYTE: be_in = 4'b0001 << off_use;
      SZ_HALF: be_in = 4'b0011 << off_use;
      default: be_in = 4'b1111;
    endcase
  end

  // Lane replication of the store data and lane split of the read data
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign din_in[8*gi +: 8] = (size_in == SZ_BYTE) ? req_wdata[7:0] :
                                 (size_in == SZ_HALF) ? req_wdata[8*(gi%2) +: 8] :
                                                        req_wdata[8*gi +: 8];
      assign rd_lane[gi] = mem_dout[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = rd_lane[off_reg];
  assign half_sel = off_reg[1] ? mem_dout[31:16] : mem_dout[15:0];

  // Sign/zero extension of the selected lane(s)
  always_comb begin
    load_data = mem_dout;
    case (f3_reg)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = mem_dout;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = err_in ? RESP : ACCESS;
      ACCESS:  state_next = we_reg ? RESP : WAIT;
      WAIT:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request capture and response registers. The response registers change
  // only on the edge that enters RESP, so they hold between responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_reg         <= 1'b0;
      f3_reg         <= 3'b000;
      off_reg        <= 2'b00;
      be_reg         <= 4'b0000;
      mem_addr_reg   <= '0;
      mem_din_reg    <= 32'd0;
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg  <= req_we;
            f3_reg  <= req_funct3;
            off_reg <= off_use;
            if (err_in) begin
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= 32'd0;
            end else begin
              mem_addr_reg <= req_addr[MEM_ADDR_WIDTH+1:2];
              mem_din_reg  <= din_in;
              be_reg       <= be_in;
            end
          end
        end
        ACCESS: begin
          if (we_reg) begin
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 32'd0;
          end
        end
        WAIT: begin
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= load_data;
        end
        default: ;
      endcase
    end
  end

  // Outputs. Reset gates the write strobe and the response combinationally
  // so an aborted request can neither write nor complete.
  assign req_ready   = (state_reg == IDLE) && rst_n;
  assign resp_valid  = (state_reg == RESP) && rst_n;
  assign mem_byte_en = (rst_n && (state_reg == ACCESS) && we_reg) ? be_reg : 4'b0000;
  assign mem_addr    = mem_addr_reg;
  assign mem_din     = mem_din_reg;
  assign resp_rdata  = resp_rdata_reg;
  assign resp_err    = resp_err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural 16-word
// write-first memory. Expectations follow the MISALIGN_TRAP_EN build option.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  mem_byte_en;
  logic [3:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int checks = 0;
  int errors = 0;

  // Observations from the last transaction
  int          o_lat;
  logic [31:0] o_rd;
  logic        o_err;
  logic [3:0]  o_be1;
  logic [3:0]  o_addr1;
  logic [31:0] o_din1;
  int          o_be_other;
  int          o_nresp;
  int          o_busy_rdy;
  logic        o_rdy_after;
  logic [31:0] o_rd_end;

  logic [31:0] exp_w2;
  logic [31:0] mem [16];

  load_store_unit #(.MEM_ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_byte_en(mem_byte_en),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem_dout = 32'd0;
  end

  // Write-first synchronous memory
  always @(posedge clk) begin
    logic [31:0] w;
    w = mem[mem_addr];
    for (int i = 0; i < 4; i++)
      if (mem_byte_en[i]) w[8*i +: 8] = mem_din[8*i +: 8];
    mem[mem_addr] <= w;
    mem_dout      <= w;
  end

  // Issue one request and watch 8 cycles after acceptance
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    o_lat       = -1;
    o_rd        = 32'd0;
    o_err       = 1'b0;
    o_be_other  = 0;
    o_nresp     = 0;
    o_busy_rdy  = 0;
    o_rdy_after = 1'b0;
    o_be1       = mem_byte_en;
    o_addr1     = mem_addr;
    o_din1      = mem_din;
    for (int c = 1; c <= 8; c++) begin
      if (c != 1 && mem_byte_en != 4'b0000) o_be_other++;
      if (resp_valid) begin
        o_nresp++;
        if (o_lat < 0) begin
          o_lat = c;
          o_rd  = resp_rdata;
          o_err = resp_err;
        end
      end
      if ((o_lat < 0 || c <= o_lat) && req_ready) o_busy_rdy++;
      if (o_lat >= 0 && c == o_lat + 1) o_rdy_after = req_ready;
      if (c == 8) o_rd_end = resp_rdata;
      else begin
        @(posedge clk);
        #1;
      end
    end
    $display("txn we=%0b f3=%03b addr=%08h wdata=%08h -> lat=%0d rdata=%08h err=%0b be1=%04b",
             we, f3, addr, wdata, o_lat, o_rd, o_err, o_be1);
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
    checks++; if (mem_byte_en !== 4'd0) begin errors++; $display("FAIL reset_be: got %b expected 0000", mem_byte_en); end
    checks++; if (mem_addr !== 4'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_din !== 32'd0) begin errors++; $display("FAIL reset_din: got %h expected 0", mem_din); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", req_ready); end
  endtask

  task automatic test_store_load_word();
    issue(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
    exp_w2 = 32'hDEADBEEF;
    checks++; if (o_be1 !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b expected 1111", o_be1); end
    checks++; if (o_addr1 !== 4'd2) begin errors++; $display("FAIL sw_addr: got %h expected 2", o_addr1); end
    checks++; if (o_din1 !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_din: got %h expected deadbeef", o_din1); end
    checks++; if (o_lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", o_lat); end
    checks++; if (o_err !== 1'b0 || o_rd !== 32'd0) begin errors++; $display("FAIL sw_resp: got err=%b rdata=%h expected err=0 rdata=0", o_err, o_rd); end
    checks++; if (o_nresp !== 1) begin errors++; $display("FAIL sw_pulse_count: got %0d expected 1", o_nresp); end
    issue(1'b0, 3'b010, 32'h8, 32'h0);
    checks++; if (o_lat !== 3) begin errors++; $display("FAIL lw_latency: got %0d expected 3", o_lat); end
    checks++; if (o_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", o_rd); end
    checks++; if (o_be1 !== 4'd0 || o_be_other !== 0) begin errors++; $display("FAIL lw_no_write: got be1=%b other=%0d expected 0000/0", o_be1, o_be_other); end
    checks++; if (o_rd_end !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_hold: got %h expected deadbeef", o_rd_end); end
  endtask

  task automatic test_byte_half_store();
    issue(1'b1, 3'b010, 32'h4, 32'h11223344);
    issue(1'b1, 3'b000, 32'h5, 32'h000000A5);
    checks++; if (o_be1 !== 4'b0010) begin errors++; $display("FAIL sb_be: got %b expected 0010", o_be1); end
    checks++; if (o_din1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_din: got %h expected a5a5a5a5", o_din1); end
    issue(1'b0, 3'b010, 32'h4, 32'h0);
    checks++; if (o_rd !== 32'h1122A544) begin errors++; $display("FAIL sb_readback: got %h expected 1122a544", o_rd); end
    issue(1'b1, 3'b001, 32'h6, 32'h0000BEEF);
    checks++; if (o_be1 !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", o_be1); end
    checks++; if (o_din1 !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_din: got %h expected beefbeef", o_din1); end
    issue(1'b0, 3'b001, 32'h6, 32'h0);
    checks++; if (o_rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_upper: got %h expected ffffbeef", o_rd); end
    issue(1'b0, 3'b000, 32'h7, 32'h0);
    checks++; if (o_rd !== 32'hFFFFFFBE) begin errors++; $display("FAIL lb_lane3: got %h expected ffffffbe", o_rd); end
    issue(1'b0, 3'b100, 32'h5, 32'h0);
    checks++; if (o_rd !== 32'h000000A5) begin errors++; $display("FAIL lbu_lane1: got %h expected 000000a5", o_rd); end
  endtask

  task automatic test_sign_extension();
    issue(1'b1, 3'b010, 32'hC, 32'h80F07F81);
    issue(1'b0, 3'b000, 32'hC, 32'h0);
    checks++; if (o_rd !== 32'hFFFFFF81) begin errors++; $display("FAIL lb: got %h expected ffffff81", o_rd); end
    issue(1'b0, 3'b100, 32'hC, 32'h0);
    checks++; if (o_rd !== 32'h00000081) begin errors++; $display("FAIL lbu: got %h expected 00000081", o_rd); end
    issue(1'b0, 3'b001, 32'hE, 32'h0);
    checks++; if (o_rd !== 32'hFFFF80F0) begin errors++; $display("FAIL lh: got %h expected ffff80f0", o_rd); end
    issue(1'b0, 3'b101, 32'hE, 32'h0);
    checks++; if (o_rd !== 32'h000080F0) begin errors++; $display("FAIL lhu: got %h expected 000080f0", o_rd); end
  endtask

  task automatic test_misaligned();
    issue(1'b1, 3'b010, 32'h0, 32'h9ABC1234);
    issue(1'b0, 3'b001, 32'h3, 32'h0);
`ifdef MISALIGN_TRAP_EN
    checks++; if (o_lat !== 1 || o_err !== 1'b1) begin errors++; $display("FAIL lh_misaligned_trap: got lat=%0d err=%b expected 1/1", o_lat, o_err); end
    checks++; if (o_rd !== 32'd0) begin errors++; $display("FAIL lh_misaligned_rdata: got %h expected 0", o_rd); end
`else
    checks++; if (o_lat !== 3 || o_err !== 1'b0) begin errors++; $display("FAIL lh_misaligned_lat: got lat=%0d err=%b expected 3/0", o_lat, o_err); end
    checks++; if (o_rd !== 32'hFFFF9ABC) begin errors++; $display("FAIL lh_misaligned_data: got %h expected ffff9abc", o_rd); end
`endif
    issue(1'b1, 3'b010, 32'hB, 32'h0BADF00D);
`ifdef MISALIGN_TRAP_EN
    checks++; if (o_lat !== 1 || o_err !== 1'b1) begin errors++; $display("FAIL sw_misaligned_trap: got lat=%0d err=%b expected 1/1", o_lat, o_err); end
    checks++; if (o_be1 !== 4'd0 || o_be_other !== 0) begin errors++; $display("FAIL sw_misaligned_nowrite: got be1=%b other=%0d expected 0000/0", o_be1, o_be_other); end
`else
    exp_w2 = 32'h0BADF00D;
    checks++; if (o_lat !== 2 || o_err !== 1'b0) begin errors++; $display("FAIL sw_misaligned_lat: got lat=%0d err=%b expected 2/0", o_lat, o_err); end
    checks++; if (o_be1 !== 4'b1111 || o_addr1 !== 4'd2) begin errors++; $display("FAIL sw_misaligned_access: got be=%b addr=%h expected 1111/2", o_be1, o_addr1); end
`endif
    issue(1'b0, 3'b010, 32'h8, 32'h0);
    checks++; if (o_rd !== exp_w2) begin errors++; $display("FAIL misaligned_word2: got %h expected %h", o_rd, exp_w2); end
  endtask

  task automatic test_illegal_funct3();
    issue(1'b0, 3'b011, 32'h8, 32'h0);
    checks++; if (o_lat !== 1 || o_err !== 1'b1) begin errors++; $display("FAIL f3_011_err: got lat=%0d err=%b expected 1/1", o_lat, o_err); end
    checks++; if (o_rd !== 32'd0) begin errors++; $display("FAIL f3_011_rdata: got %h expected 0", o_rd); end
    issue(1'b1, 3'b100, 32'h8, 32'hFFFFFFFF);
    checks++; if (o_lat !== 1 || o_err !== 1'b1) begin errors++; $display("FAIL store_f3_100_err: got lat=%0d err=%b expected 1/1", o_lat, o_err); end
    checks++; if (o_be1 !== 4'd0 || o_be_other !== 0) begin errors++; $display("FAIL store_f3_100_nowrite: got be1=%b other=%0d expected 0000/0", o_be1, o_be_other); end
    checks++; if (o_rd_end !== 32'd0 || resp_err !== 1'b1) begin errors++; $display("FAIL err_hold: got rdata=%h err=%b expected 0/1", o_rd_end, resp_err); end
    issue(1'b0, 3'b010, 32'h8, 32'h0);
    checks++; if (o_rd !== exp_w2 || o_err !== 1'b0) begin errors++; $display("FAIL after_illegal_word2: got %h err=%b expected %h/0", o_rd, o_err, exp_w2); end
  endtask

  task automatic test_reset_mid_access();
    int nresp;
    nresp = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h8;
    req_wdata  = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    $display("txn reset during ACCESS of SW addr=00000008 wdata=12345678");
    checks++; if (mem_byte_en !== 4'd0) begin errors++; $display("FAIL reset_access_be: got %b expected 0000", mem_byte_en); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_access_ready: got %b expected 0", req_ready); end
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
      if (resp_valid) nresp++;
    end
    checks++; if (nresp !== 0) begin errors++; $display("FAIL reset_access_noresp: got %0d pulses expected 0", nresp); end
    issue(1'b0, 3'b010, 32'h8, 32'h0);
    checks++; if (o_rd !== exp_w2) begin errors++; $display("FAIL reset_access_nowrite: got %h expected %h", o_rd, exp_w2); end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 3'b000, 32'h1, 32'h0000005A);
    checks++; if (o_busy_rdy !== 0 || o_rdy_after !== 1'b1) begin errors++; $display("FAIL b2b_store_ready: got busy=%0d after=%b expected 0/1", o_busy_rdy, o_rdy_after); end
    issue(1'b0, 3'b100, 32'h1, 32'h0);
    checks++; if (o_rd !== 32'h0000005A) begin errors++; $display("FAIL b2b_lbu: got %h expected 0000005a", o_rd); end
    checks++; if (o_busy_rdy !== 0 || o_rdy_after !== 1'b1) begin errors++; $display("FAIL b2b_load_ready: got busy=%0d after=%b expected 0/1", o_busy_rdy, o_rdy_after); end
    checks++; if (o_nresp !== 1) begin errors++; $display("FAIL b2b_pulse_count: got %0d expected 1", o_nresp); end
  endtask

  initial begin
    test_reset();
    test_store_load_word();
    test_byte_half_store();
    test_sign_extension();
    test_misaligned();
    test_illegal_funct3();
    test_reset_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side load/store unit placed directly upstream of the byte-addressable 32-bit write-first data memory. It accepts one RV32I load/store request at a time, derives the word address, byte enables and lane-replicated write data, and drives the memory. On loads it captures the memory's synchronous read data, then extracts, sign- or zero-extends and returns the result with a one-cycle response pulse.

## Interface
- MEM_ADDR_WIDTH, 4, word-address width of the data memory (16 words)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (right-aligned)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request rejected, no memory access made
- mem_byte_en  out  4  per-lane write enable to memory
- mem_addr  out  MEM_ADDR_WIDTH  word address, = req_addr[MEM_ADDR_WIDTH+1:2]; upper address bits ignored (wrap)
- mem_din  out  32  lane-replicated write data
- mem_dout  in  32  memory read data, valid one cycle after mem_addr is sampled

## Operation
- States: IDLE, ACCESS, WAIT, RESP. req_ready = (state==IDLE) && rst_n.
- IDLE: on req_valid, latch the request and decode. Illegal funct3 (011, 110, 111, or 100/101 with req_we=1) or trapped misalignment -> RESP with resp_err=1. Otherwise -> ACCESS.
- ACCESS: mem_addr and mem_din come from registers. Stores assert mem_byte_en, then go to RESP. Loads keep mem_byte_en=0, then go to WAIT.
- WAIT: register the extracted mem_dout into resp_rdata, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Lane offset is off=addr[1:0].
  - SB: be=0001<<off, din={4{wdata[7:0]}}.
  - SH: be=0011<<off, din={2{wdata[15:0]}}.
  - SW: be=1111, din=wdata.
- Loads: LB/LBU pick byte off, LH/LHU pick half off[1], LW takes the whole word. Sign-extend for LB/LH; zero-extend for LBU/LHU.
- Misaligned means a half access with off[0]=1, or a word access with off!=0.
- mem_byte_en=0 in every state other than ACCESS, and is forced to 0 combinationally whenever rst_n=0.

## Timing
- Accept at cycle T (req_valid && req_ready).
- Store: memory write at the edge ending T+1; resp_valid at T+2. Occupancy is 3 cycles.
- Load: address sampled at the edge ending T+1; mem_dout captured at the edge ending T+2; resp_valid at T+3. Occupancy is 4 cycles.
- Error: resp_valid=resp_err=1 at T+1. No mem_byte_en activity.
- A new request can be accepted in the cycle after RESP (IDLE).
- Reset values: state IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_byte_en=0, mem_addr=0, mem_din=0; req_ready=0 while rst_n=0.
- Reset mid-operation aborts the request: no response is produced, and no write occurs in any cycle with rst_n=0.
- The response registers (resp_rdata, resp_err) hold their values until the next response.

## Configuration
- MISALIGN_TRAP_EN defined: a misaligned request returns resp_err=1 at T+1 and makes no memory access.
- MISALIGN_TRAP_EN undefined: misaligned offsets are truncated before use (half: off[0]=0; word: off=0). The access proceeds normally with resp_err=0.
- Illegal-funct3 errors are reported in both builds.

## Test plan
- SW addr 0x8, wdata 0xDEADBEEF, then LW 0x8 -> mem_byte_en=1111 and mem_addr=2 at T+1; the load returns 0xDEADBEEF at T+3.
- SB 0x5 wdata 0x000000A5 onto word 1 = 0x11223344 -> be=0010, din=0xA5A5A5A5; LW 0x4 then returns 0x1122A544.
- Word 3 = 0x80F0_7F81: LB 0xC returns 0xFFFFFF81, LBU 0xC returns 0x00000081, LH 0xE returns 0xFFFF80F0, LHU 0xE returns 0x000080F0.
- LH 0x3 -> with MISALIGN_TRAP_EN: resp_err=1 at T+1 and no write. Without it: access at half offset 2.
- funct3=011 load, and funct3=100 store -> resp_err=1, resp_rdata=0, mem_byte_en stays 0.
- rst_n low during ACCESS of a SW -> no write (a following LW returns the old value), and no resp_valid is produced.
